// File: rtl/adler32_stream_engine.sv
// Adler-32 stream engine: takes 32-bit words, feeds them one byte per cycle (MSB first)
// into running sums A/B, and publishes {B,A} when a frame ends.
module adler32_stream_engine #(
  parameter logic [15:0] MOD_BASE = 16'd65521,
  parameter logic [15:0] INIT_A   = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_nbytes,
  output logic [15:0] sum_a,
  output logic [15:0] sum_b,
  output logic [31:0] cksum,
  output logic        cksum_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        lastf_q, lastf_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] cksum_q, cksum_d;
  logic        cksum_valid_q, cksum_valid_d;

  logic [16:0] a_sum, b_sum;
  logic [15:0] a_byte, b_byte;

  // A and B stay below MOD_BASE, so a single conditional subtract keeps them reduced.
  always_comb begin
    a_sum  = {1'b0, a_q} + {9'd0, shift_q[31:24]};
    a_byte = (a_sum >= {1'b0, MOD_BASE}) ? 16'(a_sum - {1'b0, MOD_BASE}) : a_sum[15:0];
    b_sum  = {1'b0, b_q} + {1'b0, a_byte};
    b_byte = (b_sum >= {1'b0, MOD_BASE}) ? 16'(b_sum - {1'b0, MOD_BASE}) : b_sum[15:0];
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    lastf_d       = lastf_q;
    a_d           = a_q;
    b_d           = b_q;
    cksum_d       = cksum_q;
    cksum_valid_d = 1'b0;
    s_ready       = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = rst_n;
        if (s_valid) begin
          shift_d = s_data;
          lastf_d = s_last;
          if (s_last && (s_nbytes != 3'd0)) begin
            cnt_d = s_nbytes;
          end else begin
            cnt_d = 3'd4;
          end
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d     = a_byte;
        b_d     = b_byte;
        shift_d = {shift_q[23:0], 8'h00};
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          // Result is latched on the final byte so cksum and its pulse line up in DONE.
          if (lastf_q) begin
            cksum_d       = {b_byte, a_byte};
            cksum_valid_d = 1'b1;
            state_d       = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DONE: begin
        a_d     = INIT_A;
        b_d     = 16'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= 32'd0;
      cnt_q         <= 3'd0;
      lastf_q       <= 1'b0;
      a_q           <= INIT_A;
      b_q           <= 16'd0;
      cksum_q       <= 32'h0000_0001;
      cksum_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      lastf_q       <= lastf_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cksum_q       <= cksum_d;
      cksum_valid_q <= cksum_valid_d;
    end
  end

  assign sum_a       = a_q;
  assign sum_b       = b_q;
  assign cksum       = cksum_q;
  assign cksum_valid = cksum_valid_q;

endmodule

// File: tb/tb_adler32_stream_engine.sv
// Directed bench for adler32_stream_engine: table of frames with hand-computed Adler-32
// values, plus hand-written sequences for long frames, back-to-back frames and async reset.
module tb_adler32_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic [2:0]  s_nbytes = 3'd0;
  logic        s_ready;
  logic [15:0] sum_a;
  logic [15:0] sum_b;
  logic [31:0] cksum;
  logic        cksum_valid;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          done_cyc = 0;
  logic        ready_at_done = 1'b1;
  logic [31:0] ck_hist[$];

  typedef struct {
    string       name;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          nwords;
    logic [2:0]  nbytes;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];
  vec_t vec_a;

  adler32_stream_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_nbytes    (s_nbytes),
    .sum_a       (sum_a),
    .sum_b       (sum_b),
    .cksum       (cksum),
    .cksum_valid (cksum_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every checksum pulse, when it happened and whether s_ready was low at that time.
  always @(negedge clk) begin
    if (cksum_valid === 1'b1) begin
      pulse_cnt     <= pulse_cnt + 1;
      done_cyc      <= cyc;
      ready_at_done <= s_ready;
      ck_hist.push_back(cksum);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves s_valid high after the handshake so callers can stream words back-to-back.
  task automatic sendWord(input logic [31:0] d, input logic last, input logic [2:0] nb,
                          output int hs);
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    s_nbytes = nb;
    hs       = -1;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: got no s_ready required s_ready=1 within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int base, output logic got);
    got = 1'b0;
    for (int g = 0; g < 400; g++) begin
      if (pulse_cnt > base) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no cksum_valid required one pulse within 400 cycles");
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int          base;
    int          hbase;
    int          hs;
    int          n;
    logic        got;
    logic [31:0] w;
    logic        last;
    base  = pulse_cnt;
    hbase = ck_hist.size();
    hs    = 0;
    for (int i = 0; i < v.nwords; i++) begin
      w    = (i == 0) ? v.w0 : ((i == 1) ? v.w1 : v.w2);
      last = (i == v.nwords - 1);
      // Non-last words carry a misleading nbytes that the engine must ignore.
      sendWord(w, last, last ? v.nbytes : 3'd1, hs);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDone(base, got);
    repeat (3) @(posedge clk);
    #1;
    n = (v.nbytes == 3'd0) ? 4 : int'(v.nbytes);
    if (got) begin
      checkOutput({v.name, " pulse_cksum"}, ck_hist[hbase], v.exp);
      checkOutput({v.name, " latency"}, 32'(done_cyc - hs), 32'(n + 1));
      checkOutput({v.name, " ready_at_done"}, {31'd0, ready_at_done}, 32'd0);
    end
    checkOutput({v.name, " held_cksum"}, cksum, v.exp);
    checkOutput({v.name, " pulses"}, 32'(pulse_cnt - base), 32'd1);
    checkOutput({v.name, " sum_a_idle"}, {16'd0, sum_a}, 32'd1);
    checkOutput({v.name, " sum_b_idle"}, {16'd0, sum_b}, 32'd0);
    checkOutput({v.name, " ready_idle"}, {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    int   hs;
    int   hs_a;
    int   base;
    int   hbase;
    int   done1;
    logic got;

    vecs[0] = '{"wikipedia", 32'h5769_6B69, 32'h7065_6469, 32'h6100_0000, 3, 3'd1, 32'h11E6_0398};
    vecs[1] = '{"a",         32'h6100_0000, 32'h0,        32'h0,        1, 3'd1, 32'h0062_0062};
    vecs[2] = '{"a_garbage", 32'h61AB_CDEF, 32'h0,        32'h0,        1, 3'd1, 32'h0062_0062};
    vecs[3] = '{"zero_byte", 32'h0000_0000, 32'h0,        32'h0,        1, 3'd1, 32'h0001_0001};
    vecs[4] = '{"ab",        32'h6162_FFFF, 32'h0,        32'h0,        1, 3'd2, 32'h0126_00C4};
    vecs[5] = '{"abc",       32'h6162_6300, 32'h0,        32'h0,        1, 3'd3, 32'h024D_0127};
    vecs[6] = '{"abcd_nb0",  32'h6162_6364, 32'h0,        32'h0,        1, 3'd0, 32'h03D8_018B};
    vec_a   = vecs[1];

    #12;
    checkOutput("reset s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("reset cksum", cksum, 32'h0000_0001);
    checkOutput("reset sum_a", {16'd0, sum_a}, 32'd1);
    checkOutput("reset sum_b", {16'd0, sum_b}, 32'd0);
    checkOutput("reset cksum_valid", {31'd0, cksum_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset s_ready", {31'd0, s_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // 260 bytes of 0xFF: A wraps past the modulus partway through.
    base  = pulse_cnt;
    hs    = 0;
    for (int i = 0; i < 65; i++) begin
      sendWord(32'hFFFF_FFFF, (i == 64), 3'd0, hs);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDone(base, got);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ff260 cksum", cksum, 32'h0E36_030C);
    checkOutput("ff260 latency", 32'(done_cyc - hs), 32'd5);
    checkOutput("ff260 pulses", 32'(pulse_cnt - base), 32'd1);

    // Back-to-back frames with s_valid held high throughout.
    base  = pulse_cnt;
    hbase = ck_hist.size();
    sendWord(32'h5769_6B69, 1'b0, 3'd2, hs);
    sendWord(32'h7065_6469, 1'b0, 3'd2, hs);
    sendWord(32'h6100_0000, 1'b1, 3'd1, hs);
    @(negedge clk);
    checkOutput("b2b ready_in_shift", {31'd0, s_ready}, 32'd0);
    sendWord(32'h6100_0000, 1'b1, 3'd1, hs_a);
    done1 = done_cyc;
    checkOutput("b2b ready_at_first_done", {31'd0, ready_at_done}, 32'd0);
    checkOutput("b2b handshake_after_done", 32'(hs_a - done1), 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDone(base + 1, got);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2b pulses", 32'(pulse_cnt - base), 32'd2);
    if (got) begin
      checkOutput("b2b first_cksum", ck_hist[hbase], 32'h11E6_0398);
      checkOutput("b2b second_cksum", ck_hist[hbase + 1], 32'h0062_0062);
      checkOutput("b2b second_latency", 32'(done_cyc - hs_a), 32'd2);
    end

    // Asynchronous reset between edges in the middle of a frame.
    base = pulse_cnt;
    sendWord(32'h5769_6B69, 1'b0, 3'd0, hs);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midframe sum_a", {16'd0, sum_a}, 32'h0000_0058);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("async_rst sum_a", {16'd0, sum_a}, 32'd1);
    checkOutput("async_rst sum_b", {16'd0, sum_b}, 32'd0);
    checkOutput("async_rst cksum", cksum, 32'h0000_0001);
    checkOutput("async_rst cksum_valid", {31'd0, cksum_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("async_rst no_pulse", 32'(pulse_cnt - base), 32'd0);
    applyStimulus(vec_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got simulation still running required completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
